deco_pipe: RTL and testbench

DECO_PIPE -- requirements
Module: deco_pipe

---
 rtl/deco_pipe.sv | 134 +++++++++++++
 tb/tb_deco_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deco_pipe.sv
// deco_pipe: instruction decode stage with a register file, a pending-write
// scoreboard for RAW hazards, immediate sign extension, branch target
// computation, and a single output register with a valid/ready handshake.
module deco_pipe #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  parameter  int IMM_W  = 19,
  localparam int REG_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream instruction handshake
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [REG_W-1:0]  i_ra,
  input  logic [REG_W-1:0]  i_rb,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_rd_wr,
  input  logic              i_branch,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [DATA_W-1:0] i_pc,
  // write-back port
  input  logic              i_wb_en,
  input  logic [REG_W-1:0]  i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  // downstream handshake and decoded results
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data1,
  output logic [DATA_W-1:0] o_data2,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [DATA_W-1:0] o_branch_dir,
  output logic              o_pc_select,
  output logic [REG_W-1:0]  o_rd_out,
  output logic              o_rd_wr_out
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pending;
  logic [NREGS-1:0]  w_pending_next;

  logic              w_wb_hit_a;
  logic              w_wb_hit_b;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_hazard;
  logic              w_accept;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_branch_dir;

  // Write-back port matches a source register (used for both bypass and hazard relief)
  always_comb begin
    w_wb_hit_a = i_wb_en && (i_wb_addr == i_ra);
    w_wb_hit_b = i_wb_en && (i_wb_addr == i_rb);
  end

  // Operand read: register 0 is hardwired zero, a same-cycle write-back is forwarded
  always_comb begin
    w_rdata1 = r_regs[i_ra];
    w_rdata2 = r_regs[i_rb];
    if (w_wb_hit_a) w_rdata1 = i_wb_data;
    if (w_wb_hit_b) w_rdata2 = i_wb_data;
    if (i_ra == '0) w_rdata1 = '0;
    if (i_rb == '0) w_rdata2 = '0;
  end

  // A source waiting on an outstanding write stalls, unless that write lands this cycle
  always_comb begin
    w_hazard = i_in_valid &&
               ((r_pending[i_ra] && !w_wb_hit_a) ||
                (r_pending[i_rb] && !w_wb_hit_b));
  end

  // Accept when the output slot is free (or draining) and no hazard is present
  always_comb begin
    o_in_ready = (!o_out_valid || i_out_ready) && !w_hazard;
    w_accept   = i_in_valid && o_in_ready;
  end

  // Sign-extend the immediate and form the word-scaled branch target (wraps silently)
  always_comb begin
    w_imm_ext    = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    w_branch_dir = i_pc + (w_imm_ext << 2);
  end

  // Scoreboard next state: write-back clears, an accepted writer sets, set wins a tie
  always_comb begin
    w_pending_next = r_pending;
    if (i_wb_en) w_pending_next[i_wb_addr] = 1'b0;
    if (w_accept && i_rd_wr && (i_rd != '0)) w_pending_next[i_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_next;
  end

  // Register file write; register 0 is never written so it always reads back zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != '0)) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Output register: load on accept, drop valid when drained with nothing new, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid  <= 1'b0;
      o_data1      <= '0;
      o_data2      <= '0;
      o_imm_ext    <= '0;
      o_branch_dir <= '0;
      o_pc_select  <= 1'b0;
      o_rd_out     <= '0;
      o_rd_wr_out  <= 1'b0;
    end else if (w_accept) begin
      o_out_valid  <= 1'b1;
      o_data1      <= w_rdata1;
      o_data2      <= w_rdata2;
      o_imm_ext    <= w_imm_ext;
      o_branch_dir <= w_branch_dir;
      o_pc_select  <= i_branch;
      o_rd_out     <= i_rd;
      o_rd_wr_out  <= i_rd_wr;
    end else if (i_out_ready) begin
      o_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deco_pipe.sv
// tb_deco_pipe: directed scenarios plus randomized traffic for deco_pipe,
// checked against an array-based behavioural model of the decode stage.
module tb_deco_pipe;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [3:0]  ra, rb, rd;
  logic        rdWr;
  logic        branch;
  logic [18:0] imm;
  logic [31:0] pc;
  logic        wbEn;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;
  logic        outValid;
  logic        outReady;
  logic [31:0] data1, data2, immExt, branchDir;
  logic        pcSel;
  logic [3:0]  rdOut;
  logic        rdWrOut;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] mRegs [16];
  logic        mPend [16];
  logic        mValid;
  logic [31:0] mData1, mData2, mImm, mBr;
  logic        mSel;
  logic [3:0]  mRd;
  logic        mRdWr;
  logic        expReady;
  logic        sampReady;

  deco_pipe dut (
    .clk(clk), .rst_n(rstN),
    .i_in_valid(inValid), .o_in_ready(inReady),
    .i_ra(ra), .i_rb(rb), .i_rd(rd), .i_rd_wr(rdWr),
    .i_branch(branch), .i_imm(imm), .i_pc(pc),
    .i_wb_en(wbEn), .i_wb_addr(wbAddr), .i_wb_data(wbData),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_data1(data1), .o_data2(data2), .o_imm_ext(immExt),
    .o_branch_dir(branchDir), .o_pc_select(pcSel),
    .o_rd_out(rdOut), .o_rd_wr_out(rdWrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mRegs[i] = '0;
      mPend[i] = 1'b0;
    end
    mValid = 0; mData1 = 0; mData2 = 0; mImm = 0; mBr = 0;
    mSel = 0; mRd = 0; mRdWr = 0;
  endtask

  task automatic idleInputs();
    inValid = 0; ra = 0; rb = 0; rd = 0; rdWr = 0; branch = 0;
    imm = 0; pc = 0; wbEn = 0; wbAddr = 0; wbData = 0; outReady = 1;
  endtask

  function automatic logic [31:0] readReg(input logic [3:0] idx);
    if (idx == 0) return 32'd0;
    if (wbEn && wbAddr == idx) return wbData;
    return mRegs[idx];
  endfunction

  // One clock: inputs were set at the falling edge; sample readiness, advance model, return at next falling edge
  task automatic tick();
    logic hz, acc;
    logic [31:0] sext;
    #1;
    hz = inValid && ((mPend[ra] && !(wbEn && wbAddr == ra)) ||
                     (mPend[rb] && !(wbEn && wbAddr == rb)));
    expReady  = (!mValid || outReady) && !hz;
    sampReady = inReady;
    @(posedge clk);
    acc = inValid && expReady;
    if (acc) begin
      sext   = 32'($signed(imm));
      mValid = 1;
      mData1 = readReg(ra);
      mData2 = readReg(rb);
      mImm   = sext;
      mBr    = pc + sext * 32'd4;
      mSel   = branch;
      mRd    = rd;
      mRdWr  = rdWr;
    end else if (outReady) begin
      mValid = 0;
    end
    if (wbEn) begin
      if (wbAddr != 0) mRegs[wbAddr] = wbData;
      mPend[wbAddr] = 0;
    end
    if (acc && rdWr && rd != 0) mPend[rd] = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idleInputs();
    rstN = 0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({outValid, data1, data2, immExt, branchDir, pcSel, rdOut, rdWrOut} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%0b d1=%h d2=%h imm=%h br=%h sel=%0b rd=%0d wr=%0b, want all zero",
               outValid, data1, data2, immExt, branchDir, pcSel, rdOut, rdWrOut);
    end
    total++;
    if (inReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %0b want 1", inReady);
    end
    @(negedge clk);
    rstN = 1;
  endtask

  task automatic test_wb_read();
    idleInputs();
    wbEn = 1; wbAddr = 2; wbData = 32'd10;
    tick();
    idleInputs();
    inValid = 1; ra = 2; rb = 0;
    tick();
    total++;
    if (sampReady !== 1'b1 || outValid !== 1'b1 || data1 !== 32'd10 || data2 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL wb_read: got rdy=%0b valid=%0b d1=%h d2=%h, want rdy=1 valid=1 d1=0000000a d2=00000000",
               sampReady, outValid, data1, data2);
    end
    idleInputs();
    tick();
    total++;
    if (outValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_valid: got %0b want 0", outValid);
    end
  endtask

  task automatic test_bypass();
    idleInputs();
    wbEn = 1; wbAddr = 5; wbData = 32'h1234;
    inValid = 1; ra = 5; rb = 5;
    tick();
    total++;
    if (data1 !== 32'h1234 || data2 !== 32'h1234 || outValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bypass: got d1=%h d2=%h valid=%0b, want d1=d2=00001234 valid=1", data1, data2, outValid);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_hazard();
    idleInputs();
    inValid = 1; rd = 3; rdWr = 1;
    tick();
    idleInputs();
    inValid = 1; ra = 3; rb = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (sampReady !== 1'b0 || expReady !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hazard_stall%0d: got in_ready=%0b want 0", i, sampReady);
      end
    end
    wbEn = 1; wbAddr = 3; wbData = 32'd7;
    tick();
    total++;
    if (sampReady !== 1'b1 || data1 !== 32'd7 || outValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hazard_release: got rdy=%0b d1=%h valid=%0b, want rdy=1 d1=00000007 valid=1",
               sampReady, data1, outValid);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_imm_branch();
    idleInputs();
    inValid = 1; imm = 19'h7FFFF; pc = 32'h100; branch = 1;
    tick();
    total++;
    if (immExt !== 32'hFFFFFFFF || branchDir !== 32'hFC || pcSel !== 1'b1) begin
      bad++;
      $display("[TB] FAIL imm_neg: got imm=%h br=%h sel=%0b, want ffffffff 000000fc 1", immExt, branchDir, pcSel);
    end
    imm = 19'd8; pc = 32'hFFFFFFFC; branch = 0; rd = 9; rdWr = 0;
    tick();
    total++;
    if (immExt !== 32'd8 || branchDir !== 32'h1C || pcSel !== 1'b0 || rdOut !== 4'd9 || rdWrOut !== 1'b0) begin
      bad++;
      $display("[TB] FAIL branch_wrap: got imm=%h br=%h sel=%0b rd=%0d wr=%0b, want 00000008 0000001c 0 9 0",
               immExt, branchDir, pcSel, rdOut, rdWrOut);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] heldBr;
    idleInputs();
    inValid = 1; pc = 32'hAAA0; imm = 19'd1;
    tick();
    heldBr = branchDir;
    outReady = 0; pc = 32'h5550; imm = 19'd2; branch = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sampReady !== 1'b0 || outValid !== 1'b1 || branchDir !== heldBr || branchDir !== 32'hAAA4 || pcSel !== 1'b0) begin
        bad++;
        $display("[TB] FAIL backpressure_hold%0d: got rdy=%0b valid=%0b br=%h sel=%0b, want rdy=0 valid=1 br=0000aaa4 sel=0",
                 i, sampReady, outValid, branchDir, pcSel);
      end
    end
    outReady = 1;
    tick();
    total++;
    if (sampReady !== 1'b1 || outValid !== 1'b1 || branchDir !== 32'h5558 || pcSel !== 1'b1) begin
      bad++;
      $display("[TB] FAIL backpressure_release: got rdy=%0b valid=%0b br=%h sel=%0b, want 1 1 00005558 1",
               sampReady, outValid, branchDir, pcSel);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idleInputs();
    wbEn = 1; wbAddr = 4; wbData = 32'h55;
    tick();
    idleInputs();
    inValid = 1; rd = 4; rdWr = 1;
    tick();
    idleInputs();
    inValid = 1; ra = 4; outReady = 0;
    tick();
    total++;
    if (sampReady !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_stall_pre: got in_ready=%0b want 0", sampReady);
    end
    #2 rstN = 0;
    modelReset();
    #1;
    total++;
    if (outValid !== 1'b0 || data1 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got valid=%0b d1=%h, want 0 00000000", outValid, data1);
    end
    @(negedge clk);
    rstN = 1;
    outReady = 1; rd = 0; rdWr = 0;
    tick();
    total++;
    if (sampReady !== 1'b1 || outValid !== 1'b1 || data1 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL post_reset_r4: got rdy=%0b valid=%0b d1=%h, want 1 1 00000000", sampReady, outValid, data1);
    end
    idleInputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      ra       = 4'($urandom_range(0, 15));
      rb       = 4'($urandom_range(0, 15));
      rd       = 4'($urandom_range(0, 15));
      rdWr     = 1'($urandom_range(0, 1));
      branch   = 1'($urandom_range(0, 1));
      imm      = 19'($urandom);
      pc       = $urandom;
      wbEn     = ($urandom_range(0, 9) < 5);
      wbAddr   = 4'($urandom_range(0, 15));
      wbData   = $urandom;
      outReady = ($urandom_range(0, 9) < 7);
      tick();
      total++;
      if (sampReady !== expReady) begin
        bad++;
        $display("[TB] FAIL rand_ready[%0d]: got %0b want %0b", n, sampReady, expReady);
      end
      total++;
      if ({outValid, data1, data2, immExt, branchDir, pcSel, rdOut, rdWrOut} !==
          {mValid, mData1, mData2, mImm, mBr, mSel, mRd, mRdWr}) begin
        bad++;
        $display("[TB] FAIL rand_out[%0d]: got v=%0b %h %h %h %h %0b %0d %0b want v=%0b %h %h %h %h %0b %0d %0b",
                 n, outValid, data1, data2, immExt, branchDir, pcSel, rdOut, rdWrOut,
                 mValid, mData1, mData2, mImm, mBr, mSel, mRd, mRdWr);
      end
    end
    idleInputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    idleInputs();
    rstN = 0;
    modelReset();
    @(negedge clk);
    test_reset();
    test_wb_read();
    test_bypass();
    test_hazard();
    test_imm_branch();
    test_backpressure();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
